month_counter: RTL and testbench

MONTH_COUNTER -- requirements
Module: month_counter

---
 rtl/month_counter.sv | 113 +++++++++++
 tb/tb_month_counter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/month_counter.sv
// Month stage of a calendar chain: advances 1..12 on a day-counter wrap (run mode)
// or on a button press (month-set mode), and reports month length and a 7-segment image.
module month_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        up,
    input  logic [1:0]  set,
    input  logic        day_carry,
    input  logic        leap_year,
    output logic [3:0]  month_count,
    output logic [4:0]  day_case,
    output logic        month_carry,
    output logic [13:0] month_7seg
);

    typedef enum logic [1:0] {
        SET_RUN   = 2'b00,
        SET_DAY   = 2'b01,
        SET_MONTH = 2'b10,
        SET_YEAR  = 2'b11
    } mode_e;

    mode_e       mode;
    logic        up_q;
    logic        day_carry_q;
    logic        init_q;
    logic [3:0]  month_q;
    logic [3:0]  month_d;
    logic        carry_q;
    logic        carry_d;
    logic        up_rise;
    logic        carry_rise;
    logic        advance;
    logic [3:0]  ones_digit;
    logic        tens_digit;

    assign mode       = mode_e'(set);
    assign up_rise    = up & ~up_q;
    assign carry_rise = day_carry & ~day_carry_q;

    // init_q masks the first cycle after reset, so a level held through reset
    // deassertion does not count as an edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        advance = 1'b0;
        carry_d = 1'b0;
        month_d = month_q;
        unique case (mode)
            SET_RUN:   advance = carry_rise;
            SET_MONTH: advance = up_rise;
            default:   advance = 1'b0;
        endcase
        if (advance && !init_q) begin
            if (month_q >= 4'd12 || month_q == 4'd0) begin
                month_d = 4'd1;
            end else begin
                month_d = month_q + 4'd1;
            end
            carry_d = (month_q == 4'd12) && (mode == SET_RUN);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            up_q        <= 1'b0;
            day_carry_q <= 1'b0;
            init_q      <= 1'b1;
            month_q     <= 4'd1;
            carry_q     <= 1'b0;
        end else begin
            up_q        <= up;
            day_carry_q <= day_carry;
            init_q      <= 1'b0;
            month_q     <= month_d;
            carry_q     <= carry_d;
        end
    end

    always_comb begin
        day_case = 5'd31;
        unique case (month_q)
            4'd4, 4'd6, 4'd9, 4'd11: day_case = 5'd30;
            4'd2:                    day_case = leap_year ? 5'd29 : 5'd28;
            default:                 day_case = 5'd31;
        endcase
    end

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        logic [6:0] seg;
        unique case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    assign tens_digit  = (month_q >= 4'd10);
    assign ones_digit  = tens_digit ? (month_q - 4'd10) : month_q;
    assign month_7seg  = {seg_of({3'b000, tens_digit}), seg_of(ones_digit)};
    assign month_count = month_q;
    assign month_carry = carry_q;

endmodule

// File: tb/tb_month_counter.sv
// Bench for month_counter: a vector table, directed corner sequences, and random
// stimulus scored against a calendar-level reference model.
module tb_month_counter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        up = 1'b0;
    logic [1:0]  set = 2'b00;
    logic        day_carry = 1'b0;
    logic        leap_year = 1'b0;
    logic [3:0]  month_count;
    logic [4:0]  day_case;
    logic        month_carry;
    logic [13:0] month_7seg;

    int checks = 0;
    int failures = 0;

    // reference model state: calendar month, last seen levels, carry pulse
    int m_month = 1;
    bit m_carry = 1'b0;
    bit m_prev_up = 1'b0;
    bit m_prev_dc = 1'b0;
    bit m_fresh = 1'b1;

    month_counter dut (
        .clock       (clock),
        .reset       (reset),
        .up          (up),
        .set         (set),
        .day_carry   (day_carry),
        .leap_year   (leap_year),
        .month_count (month_count),
        .day_case    (day_case),
        .month_carry (month_carry),
        .month_7seg  (month_7seg)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit       rst;
        bit       up;
        bit [1:0] set;
        bit       dc;
        bit       leap;
        int       month;
        int       days;
        bit       carry;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int days_of(input int m, input bit leap);
        int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m < 1 || m > 12) return 31;
        if (m == 2 && leap) return 29;
        return tbl[m - 1];
    endfunction

    function automatic logic [13:0] seg_image(input int m);
        logic [6:0] digits[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return {digits[m / 10], digits[m % 10]};
    endfunction

    function automatic vec_t mk(input bit rst, input bit u, input bit [1:0] s, input bit dc,
                                input bit leap, input int mo, input int dy, input bit c);
        vec_t v;
        v.rst = rst; v.up = u; v.set = s; v.dc = dc; v.leap = leap;
        v.month = mo; v.days = dy; v.carry = c;
        return v;
    endfunction

    // Drive one cycle of inputs, let the edge happen, advance the model, sample 1ns later.
    task automatic step(input bit rst, input bit u, input bit [1:0] s, input bit dc, input bit leap);
        bit rise_up;
        bit rise_dc;
        bit ev;
        @(negedge clock);
        reset = rst; up = u; set = s; day_carry = dc; leap_year = leap;
        @(posedge clock);
        if (rst) begin
            m_month = 1; m_carry = 0; m_prev_up = 0; m_prev_dc = 0; m_fresh = 1;
        end else begin
            rise_up = u && !m_prev_up;
            rise_dc = dc && !m_prev_dc;
            ev = (s == 2'b10) ? rise_up : (s == 2'b00) ? rise_dc : 1'b0;
            if (m_fresh) ev = 0;
            m_carry = ev && (m_month == 12) && (s == 2'b00);
            if (ev) m_month = (m_month >= 12 || m_month < 1) ? 1 : m_month + 1;
            m_prev_up = u; m_prev_dc = dc; m_fresh = 0;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".month"}, int'(month_count), m_month);
        check({tag, ".days"}, int'(day_case), days_of(m_month, leap_year));
        check({tag, ".carry"}, int'(month_carry), int'(m_carry));
        check({tag, ".seg"}, int'(month_7seg), int'(seg_image(m_month)));
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 2'b00, 0, 0, 1, 31, 0);
        vecs[1]  = mk(0, 0, 2'b00, 0, 0, 1, 31, 0);
        vecs[2]  = mk(0, 0, 2'b00, 1, 0, 2, 28, 0);
        vecs[3]  = mk(0, 0, 2'b00, 1, 1, 2, 29, 0);
        vecs[4]  = mk(0, 0, 2'b00, 0, 1, 2, 29, 0);
        vecs[5]  = mk(0, 1, 2'b01, 1, 0, 2, 28, 0);
        vecs[6]  = mk(0, 0, 2'b01, 0, 0, 2, 28, 0);
        vecs[7]  = mk(0, 1, 2'b10, 0, 0, 3, 31, 0);
        vecs[8]  = mk(0, 1, 2'b10, 0, 0, 3, 31, 0);
        vecs[9]  = mk(0, 1, 2'b10, 0, 0, 3, 31, 0);
        vecs[10] = mk(0, 0, 2'b10, 0, 0, 3, 31, 0);
        vecs[11] = mk(0, 1, 2'b00, 0, 0, 3, 31, 0);
        vecs[12] = mk(0, 0, 2'b00, 1, 0, 4, 30, 0);
        vecs[13] = mk(0, 0, 2'b10, 0, 0, 4, 30, 0);
        vecs[14] = mk(0, 0, 2'b10, 1, 0, 4, 30, 0);

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].rst, vecs[i].up, vecs[i].set, vecs[i].dc, vecs[i].leap);
            check($sformatf("vec%0d.month", i), int'(month_count), vecs[i].month);
            check($sformatf("vec%0d.days", i), int'(day_case), vecs[i].days);
            check($sformatf("vec%0d.carry", i), int'(month_carry), int'(vecs[i].carry));
            check($sformatf("vec%0d.seg", i), int'(month_7seg), int'(seg_image(vecs[i].month)));
        end

        // reset, then 11 day wraps in run mode reach December
        step(1, 0, 2'b00, 0, 0);
        step(0, 0, 2'b00, 0, 0);
        check("rst.seg01", int'(month_7seg), int'({7'b1000000, 7'b1111001}));
        for (int i = 0; i < 11; i++) begin
            step(0, 0, 2'b00, 1, 0);
            step(0, 0, 2'b00, 0, 0);
        end
        check("dec.month", int'(month_count), 12);
        check("dec.days", int'(day_case), 31);
        check("dec.seg", int'(month_7seg), int'({7'b1111001, 7'b0100100}));

        // December wrap in run mode: carry for exactly one cycle
        step(0, 0, 2'b00, 1, 0);
        check("wrap.month", int'(month_count), 1);
        check("wrap.carry", int'(month_carry), 1);
        step(0, 0, 2'b00, 1, 0);
        check("wrap.carry_gone", int'(month_carry), 0);
        step(0, 0, 2'b00, 0, 0);

        // February: leap_year flips day_case combinationally, month untouched
        step(0, 0, 2'b00, 1, 0);
        step(0, 0, 2'b00, 0, 0);
        check("feb.days28", int'(day_case), 28);
        leap_year = 1'b1;
        #1;
        check("feb.days29", int'(day_case), 29);
        check("feb.month", int'(month_count), 2);

        // held button in month-set mode yields one increment
        for (int i = 0; i < 5; i++) step(0, 1, 2'b10, 0, 1);
        step(0, 0, 2'b10, 0, 1);
        check("held.month", int'(month_count), 3);

        // walk to December by button, then wrap without carry
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 2'b10, 0, 0);
            step(0, 0, 2'b10, 0, 0);
        end
        check("set.dec", int'(month_count), 12);
        step(0, 1, 2'b10, 0, 0);
        check("set.wrap.month", int'(month_count), 1);
        check("set.wrap.carry", int'(month_carry), 0);
        step(0, 0, 2'b10, 0, 0);

        // day-set mode ignores both sources
        step(0, 1, 2'b01, 1, 0);
        step(0, 0, 2'b01, 0, 0);
        check("dayset.month", int'(month_count), 1);
        check("dayset.carry", int'(month_carry), 0);

        // reset wins over a simultaneous day wrap at July
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 2'b00, 1, 0);
            step(0, 0, 2'b00, 0, 0);
        end
        check("jul.month", int'(month_count), 7);
        step(1, 0, 2'b00, 1, 0);
        check("rstprio.month", int'(month_count), 1);
        check("rstprio.carry", int'(month_carry), 0);

        // button held through reset deassertion does not count
        step(1, 1, 2'b10, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 2'b10, 0, 0);
        check("heldrst.month", int'(month_count), 1);
        step(0, 0, 2'b10, 0, 0);
        step(0, 1, 2'b10, 0, 0);
        check("heldrst.after", int'(month_count), 2);

        // random stimulus against the model
        step(1, 0, 2'b00, 0, 0);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) == 0), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 1), $urandom_range(0, 1));
            check_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
